// File: rtl/snow64_mem_responder_pkg.sv
// Shared Snow64 CPU port types and the memory-responder FSM state encoding.
// PkgSnow64Cpu is the CPU-facing package; PkgSnow64MemResponder is local to the responder.
package PkgSnow64Cpu;
    localparam int CPU_ADDR_WIDTH    = 64;
    localparam int LAR_DATA_WIDTH    = 256;
    localparam int LINE_OFFSET_WIDTH = 5;

    typedef logic [CPU_ADDR_WIDTH-1:0] CpuAddr;
    typedef logic [LAR_DATA_WIDTH-1:0] LarData;

    typedef enum logic {
        MemAccTypRead  = 1'b0,
        MemAccTypWrite = 1'b1
    } MemAccessType;

    typedef struct packed {
        logic         req;
        CpuAddr       addr;
        LarData       data;
        MemAccessType mem_acc_type;
    } PortOut_Cpu;

    typedef struct packed {
        logic   valid;
        LarData data;
    } PortIn_Cpu;
endpackage

package PkgSnow64MemResponder;
    typedef enum logic [1:0] {
        MrStIdle,
        MrStWait,
        MrStResp
    } MemRespState;
endpackage

// File: rtl/snow64_mem_responder_ram.sv
// Single-port line-wide synchronous RAM with a one-cycle registered read.
module snow64_mem_responder_ram #(
    parameter int DEPTH_LINES = 256,
    parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [255:0]     wdata,
    output logic [255:0]     rdata
);
    logic [255:0] mem [DEPTH_LINES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/snow64_mem_responder.sv
// Memory-side responder for the Snow64 CPU port: one outstanding request, fixed latency.
// Optional out-of-range detection and out_err port: SNOW64_MEM_RESPONDER_BOUNDS_CHECK_EN.
module snow64_mem_responder
    import PkgSnow64Cpu::*;
    import PkgSnow64MemResponder::*;
#(
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [321:0] in_cpu_port,
    output logic [256:0] out_cpu_port,
    output logic         out_busy
`ifdef SNOW64_MEM_RESPONDER_BOUNDS_CHECK_EN
    ,
    output logic         out_err
`endif
);
    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    PortOut_Cpu   in_port;
    MemRespState  state_reg;
    logic [CNT_W-1:0] counter_reg;
    logic [IDX_W-1:0] idx_reg;
    LarData       data_reg;
    MemAccessType type_reg;
    logic         oor_reg;
    logic         valid_reg;
    LarData       hold_data_reg;

    logic [IDX_W-1:0] in_idx, cur_idx;
    logic         in_oor, cur_oor;
    LarData       cur_data, resp_data, out_data, ram_rdata;
    MemAccessType cur_type;
    logic         idle, accept, go_resp, ram_we;
    logic         unused_addr_bits;

    assign in_port          = in_cpu_port;
    assign unused_addr_bits = ^in_port.addr;

    always_comb begin
        idle   = (state_reg == MrStIdle);
        accept = idle && in_port.req;
        in_idx = in_port.addr[LINE_OFFSET_WIDTH +: IDX_W];
`ifdef SNOW64_MEM_RESPONDER_BOUNDS_CHECK_EN
        in_oor = |(in_port.addr >> (LINE_OFFSET_WIDTH + IDX_W));
`else
        in_oor = 1'b0;
`endif
        // In IDLE the RAM is driven straight from the port so a LATENCY=1 access lands in time.
        cur_idx  = idle ? in_idx : idx_reg;
        cur_oor  = idle ? in_oor : oor_reg;
        cur_data = idle ? in_port.data : data_reg;
        cur_type = idle ? in_port.mem_acc_type : type_reg;
        // The counter reaching zero on this edge is the transition into RESP.
        go_resp  = (LATENCY == 1) ? accept
                 : ((state_reg == MrStWait) && (counter_reg == CNT_W'(1)));
        ram_we   = rst_n && go_resp && (cur_type == MemAccTypWrite) && !cur_oor;

        resp_data = (type_reg == MemAccTypWrite) ? data_reg
                  : (oor_reg ? '0 : ram_rdata);
        out_data  = (state_reg == MrStResp) ? resp_data : hold_data_reg;
    end

    snow64_mem_responder_ram #(
        .DEPTH_LINES(DEPTH_LINES),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (cur_idx),
        .wdata(cur_data),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= MrStIdle;
            counter_reg   <= '0;
            idx_reg       <= '0;
            data_reg      <= '0;
            type_reg      <= MemAccTypRead;
            oor_reg       <= 1'b0;
            valid_reg     <= 1'b0;
            hold_data_reg <= '0;
        end else begin
            case (state_reg)
                MrStIdle: begin
                    valid_reg <= 1'b0;
                    if (in_port.req) begin
                        idx_reg     <= in_idx;
                        data_reg    <= in_port.data;
                        type_reg    <= in_port.mem_acc_type;
                        oor_reg     <= in_oor;
                        counter_reg <= CNT_W'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state_reg <= MrStResp;
                            valid_reg <= 1'b1;
                        end else begin
                            state_reg <= MrStWait;
                        end
                    end
                end
                MrStWait: begin
                    counter_reg <= counter_reg - CNT_W'(1);
                    if (go_resp) begin
                        state_reg <= MrStResp;
                        valid_reg <= 1'b1;
                    end
                end
                MrStResp: begin
                    state_reg     <= MrStIdle;
                    valid_reg     <= 1'b0;
                    hold_data_reg <= resp_data;
                end
                default: begin
                    state_reg <= MrStIdle;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_cpu_port = {valid_reg, out_data};
    assign out_busy     = (state_reg != MrStIdle);
`ifdef SNOW64_MEM_RESPONDER_BOUNDS_CHECK_EN
    assign out_err      = valid_reg && oor_reg;
`endif
endmodule

// File: tb/tb_snow64_mem_responder.sv
// Directed bench for snow64_mem_responder: LATENCY 2 main instance plus LATENCY 1 and 5.
module tb_snow64_mem_responder;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         req;
    logic [63:0]  addr;
    logic [255:0] data;
    logic         typ;
    logic [321:0] in_port;
    logic [256:0] out2, out1, out5;
    logic         busy2, busy1, busy5;
`ifdef SNOW64_MEM_RESPONDER_BOUNDS_CHECK_EN
    logic         err2, err1, err5;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_W  = {8{32'h1234_5678}};
    localparam logic [255:0] PAT_Y  = {8{32'h0BAD_F00D}};
    localparam logic [255:0] PAT_D4 = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] PAT_D5 = {8{32'hCAFE_0001}};
    localparam logic [255:0] PAT_D6 = {8{32'h6666_7777}};
    localparam logic [255:0] PAT_P  = {8{32'h0101_0202}};
    localparam logic [255:0] PAT_Q  = {8{32'hFEED_FACE}};

    assign in_port = {req, addr, data, typ};
    always #5 clk = ~clk;

    snow64_mem_responder #(.DEPTH_LINES(256), .LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_cpu_port(in_port), .out_cpu_port(out2), .out_busy(busy2)
`ifdef SNOW64_MEM_RESPONDER_BOUNDS_CHECK_EN
        , .out_err(err2)
`endif
    );
    snow64_mem_responder #(.DEPTH_LINES(256), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_cpu_port(in_port), .out_cpu_port(out1), .out_busy(busy1)
`ifdef SNOW64_MEM_RESPONDER_BOUNDS_CHECK_EN
        , .out_err(err1)
`endif
    );
    snow64_mem_responder #(.DEPTH_LINES(256), .LATENCY(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_cpu_port(in_port), .out_cpu_port(out5), .out_busy(busy5)
`ifdef SNOW64_MEM_RESPONDER_BOUNDS_CHECK_EN
        , .out_err(err5)
`endif
    );

    // Drives one request on the main instance and reports first-valid edge, data, and valid count.
    task automatic issue(input logic t, input logic [63:0] a, input logic [255:0] d,
                         output int lat, output logic [255:0] rd, output int nvalid);
        @(negedge clk);
        req = 1'b1; typ = t; addr = a; data = d;
        lat = 0; nvalid = 0; rd = '0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (out2[256]) begin
                nvalid++;
                if (lat == 0) begin
                    lat = k;
                    rd  = out2[255:0];
                    req = 1'b0;
                end
            end
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b1; typ = 1'b1; addr = 64'h40; data = '1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out2[256] !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out2[256]); end
            n_checks++;
            if (out2[255:0] !== 256'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", out2[255:0]); end
            n_checks++;
            if ({busy1, busy2, busy5} !== 3'b000) begin n_fail++; $display("FAIL reset_busy got=%b exp=000", {busy1, busy2, busy5}); end
        end
        @(negedge clk);
        req = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept busy got=%b exp=0", busy2); end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat, nv;
        logic [255:0] rd;
        issue(1'b1, 64'h40, PAT_A5, lat, rd, nv);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL wr_latency got=%0d exp=2", lat); end
        n_checks++;
        if (nv !== 1) begin n_fail++; $display("FAIL wr_valid_cycles got=%0d exp=1", nv); end
        n_checks++;
        if (rd !== PAT_A5) begin n_fail++; $display("FAIL wr_echo got=%h exp=%h", rd, PAT_A5); end
        issue(1'b0, 64'h40, '0, lat, rd, nv);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL rd_latency got=%0d exp=2", lat); end
        n_checks++;
        if (nv !== 1) begin n_fail++; $display("FAIL rd_valid_cycles got=%0d exp=1", nv); end
        n_checks++;
        if (rd !== PAT_A5) begin n_fail++; $display("FAIL rd_data got=%h exp=%h", rd, PAT_A5); end
        n_checks++;
        if (out2[255:0] !== PAT_A5) begin n_fail++; $display("FAIL rd_data_hold got=%h exp=%h", out2[255:0], PAT_A5); end
    endtask

    task automatic test_wrap();
        int lat, nv;
        logic [255:0] rd;
`ifdef SNOW64_MEM_RESPONDER_BOUNDS_CHECK_EN
        issue(1'b1, 64'h20, PAT_Y, lat, rd, nv);
        @(negedge clk);
        req = 1'b1; typ = 1'b1; addr = 64'h2020; data = PAT_W;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if ({out2[256], err2} !== 2'b11) begin n_fail++; $display("FAIL oor_err got=%b exp=11", {out2[256], err2}); end
        req = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (err2 !== 1'b0) begin n_fail++; $display("FAIL oor_err_clear got=%b exp=0", err2); end
        issue(1'b0, 64'h20, '0, lat, rd, nv);
        n_checks++;
        if (rd !== PAT_Y) begin n_fail++; $display("FAIL oor_write_suppressed got=%h exp=%h", rd, PAT_Y); end
`else
        issue(1'b1, 64'h2020, PAT_W, lat, rd, nv);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL wrap_wr_latency got=%0d exp=2", lat); end
        issue(1'b0, 64'h0020, '0, lat, rd, nv);
        n_checks++;
        if (rd !== PAT_W) begin n_fail++; $display("FAIL wrap_rd_data got=%h exp=%h", rd, PAT_W); end
`endif
    endtask

    task automatic test_handshake();
        int lat, nv;
        logic [255:0] rd;
        issue(1'b1, 64'hE0, PAT_D6, lat, rd, nv);
        @(negedge clk);
        req = 1'b1; typ = 1'b1; addr = 64'hC0; data = PAT_D4;
        @(posedge clk); #1;
        n_checks++;
        if ({busy2, out2[256]} !== 2'b10) begin n_fail++; $display("FAIL hs_accept busy,valid got=%b exp=10", {busy2, out2[256]}); end
        addr = 64'hE0; data = PAT_D5;
        @(posedge clk); #1;
        n_checks++;
        if (out2 !== {1'b1, PAT_D4}) begin n_fail++; $display("FAIL hs_first_resp got=%h exp=%h", out2, {1'b1, PAT_D4}); end
        typ = 1'b0; addr = 64'hC0;
        @(posedge clk); #1;
        n_checks++;
        if ({busy2, out2[256]} !== 2'b00) begin n_fail++; $display("FAIL hs_idle busy,valid got=%b exp=00", {busy2, out2[256]}); end
        @(posedge clk); #1;
        n_checks++;
        if ({busy2, out2[256]} !== 2'b10) begin n_fail++; $display("FAIL hs_second_accept busy,valid got=%b exp=10", {busy2, out2[256]}); end
        @(posedge clk); #1;
        n_checks++;
        if (out2 !== {1'b1, PAT_D4}) begin n_fail++; $display("FAIL hs_second_resp got=%h exp=%h", out2, {1'b1, PAT_D4}); end
        req = 1'b0;
        @(negedge clk);
        issue(1'b0, 64'hE0, '0, lat, rd, nv);
        n_checks++;
        if (rd !== PAT_D6) begin n_fail++; $display("FAIL hs_midwait_addr_ignored got=%h exp=%h", rd, PAT_D6); end
    endtask

    task automatic test_reset_mid_op();
        int lat, nv, vseen;
        logic [255:0] rd;
        issue(1'b1, 64'h80, PAT_P, lat, rd, nv);
        @(negedge clk);
        req = 1'b1; typ = 1'b1; addr = 64'h80; data = PAT_Q;
        @(posedge clk); #1;
        n_checks++;
        if (busy2 !== 1'b1) begin n_fail++; $display("FAIL mid_accept busy got=%b exp=1", busy2); end
        rst_n = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({out2[256], busy2, out2[255:0]} !== {2'b00, 256'h0}) begin
            n_fail++; $display("FAIL mid_reset_state got=%h exp=0", {out2[256], busy2, out2[255:0]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        vseen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (out2[256]) vseen++;
        end
        n_checks++;
        if (vseen !== 0) begin n_fail++; $display("FAIL mid_no_valid got=%0d exp=0", vseen); end
        issue(1'b0, 64'h80, '0, lat, rd, nv);
        n_checks++;
        if (rd !== PAT_P) begin n_fail++; $display("FAIL mid_write_lost got=%h exp=%h", rd, PAT_P); end
    endtask

    task automatic test_latency();
        int lat1, lat2, lat5, nv1, nv2, nv5;
        logic [255:0] d1, d2, d5;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        lat1 = 0; lat2 = 0; lat5 = 0; nv1 = 0; nv2 = 0; nv5 = 0;
        d1 = '0; d2 = '0; d5 = '0;
        req = 1'b1; typ = 1'b0; addr = 64'h40; data = '0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            req = 1'b0;
            if (out1[256]) begin nv1++; if (lat1 == 0) begin lat1 = k; d1 = out1[255:0]; end end
            if (out2[256]) begin nv2++; if (lat2 == 0) begin lat2 = k; d2 = out2[255:0]; end end
            if (out5[256]) begin nv5++; if (lat5 == 0) begin lat5 = k; d5 = out5[255:0]; end end
        end
        n_checks++;
        if (lat1 !== 1) begin n_fail++; $display("FAIL lat1 got=%0d exp=1", lat1); end
        n_checks++;
        if (lat2 !== 2) begin n_fail++; $display("FAIL lat2 got=%0d exp=2", lat2); end
        n_checks++;
        if (lat5 !== 5) begin n_fail++; $display("FAIL lat5 got=%0d exp=5", lat5); end
        n_checks++;
        if ({nv1, nv2, nv5} !== {32'd1, 32'd1, 32'd1}) begin n_fail++; $display("FAIL lat_valid_cycles got=%0d,%0d,%0d exp=1,1,1", nv1, nv2, nv5); end
        n_checks++;
        if (d1 !== PAT_A5) begin n_fail++; $display("FAIL lat1_data got=%h exp=%h", d1, PAT_A5); end
        n_checks++;
        if (d2 !== PAT_A5) begin n_fail++; $display("FAIL lat2_data got=%h exp=%h", d2, PAT_A5); end
        n_checks++;
        if (d5 !== PAT_A5) begin n_fail++; $display("FAIL lat5_data got=%h exp=%h", d5, PAT_A5); end
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; typ = 1'b0; addr = '0; data = '0;
        @(negedge clk);
        test_reset();
        $display("test_reset done: %0d checks, %0d failures so far", n_checks, n_fail);
        test_write_read();
        $display("test_write_read done: %0d checks, %0d failures so far", n_checks, n_fail);
        test_wrap();
        $display("test_wrap done: %0d checks, %0d failures so far", n_checks, n_fail);
        test_handshake();
        $display("test_handshake done: %0d checks, %0d failures so far", n_checks, n_fail);
        test_reset_mid_op();
        $display("test_reset_mid_op done: %0d checks, %0d failures so far", n_checks, n_fail);
        test_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
